// File: rtl/id_hazard_ctrl.sv
// ============================================================================
// Module   : id_hazard_ctrl
// Purpose  : ID-stage register scoreboard with stall/issue control.
//            Optional stall counter enabled by macro ID_HAZARD_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_writes_rd,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        stall_id,
  output logic        issue,
  output logic [31:0] busy_mask,
`ifdef ID_HAZARD_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic [5:0]  inflight
);

  typedef enum logic [0:0] {
    READY = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;
  logic [31:0] w_busy_view;
  logic [5:0]  r_inflight;
  logic [5:0]  w_inflight_nxt;
  logic        w_hazard;
  logic        w_set;
  logic        w_clr;
  logic        w_clr_eff;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  // While in reset the hazard check sees the reset (empty) scoreboard.
  assign w_busy_view = rst ? 32'd0 : r_busy;

  // A same-cycle write-back is deliberately not forwarded: the old busy bit
  // still counts, so the consumer issues one cycle after the write-back.
  assign w_hazard = id_valid &
                    ((id_uses_rs1  & w_busy_view[id_rs1]) |
                     (id_uses_rs2  & w_busy_view[id_rs2]) |
                     (id_writes_rd & w_busy_view[id_rd]));

  assign stall_id = w_hazard & ~flush;
  assign issue    = id_valid & ~w_hazard & ~flush;

  assign w_set      = issue & id_writes_rd & (id_rd != 5'd0);
  assign w_clr      = wb_valid & (wb_rd != 5'd0) & r_busy[wb_rd];
  assign w_clr_eff  = w_clr & ~(w_set & (id_rd == wb_rd));
  assign w_set_mask = w_set     ? (32'd1 << id_rd) : 32'd0;
  assign w_clr_mask = w_clr_eff ? (32'd1 << wb_rd) : 32'd0;

  always_comb begin
    w_busy_nxt      = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_nxt[0]   = 1'b0;
    w_inflight_nxt  = r_inflight;
    if (w_set && !w_clr_eff) begin
      w_inflight_nxt = r_inflight + 6'd1;
    end else if (!w_set && w_clr_eff) begin
      w_inflight_nxt = r_inflight - 6'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      READY:   if (stall_id) w_state_nxt = STALL;
      STALL:   if (flush || !stall_id) w_state_nxt = READY;
      default: w_state_nxt = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= READY;
      r_busy     <= 32'd0;
      r_inflight <= 6'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  assign busy_mask = r_busy;
  assign inflight  = r_inflight;

  // The stall state is a registered copy of the previous cycle's stall.
  a_state_tracks_stall: assert property (
    @(posedge clk) disable iff (rst) (r_state == STALL) == $past(stall_id)
  );

`ifdef ID_HAZARD_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (stall_id && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  logic w_cnt_unused;
  assign w_cnt_unused = ^c_cnt_max;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
// ============================================================================
// Module   : tb_id_hazard_ctrl
// Purpose  : Directed scoreboard bench for id_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_writes_rd;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall_id;
  logic        issue;
  logic [31:0] busy_mask;
  logic [5:0]  inflight;
`ifdef ID_HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total;
  int bad;

  typedef struct {
    string       tag;
    logic        stall;
    logic        iss;
    logic [31:0] busy;
    logic [5:0]  infl;
  } exp_t;

  exp_t sb[$];

  id_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_writes_rd (id_writes_rd),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .stall_id     (stall_id),
    .issue        (issue),
    .busy_mask    (busy_mask),
`ifdef ID_HAZARD_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .inflight     (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_writes_rd = 0;
    flush = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the cycle currently driven, sample mid-cycle,
  // then advance to just after the next rising edge.
  task automatic cyc(string tag, logic s, logic i, logic [31:0] b, logic [5:0] n);
    exp_t e;
    e.tag = tag; e.stall = s; e.iss = i; e.busy = b; e.infl = n;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk1({e.tag, ".stall"}, stall_id, e.stall);
    chk1({e.tag, ".issue"}, issue, e.iss);
    chkw({e.tag, ".busy"}, busy_mask, e.busy);
    chkw({e.tag, ".infl"}, {26'd0, inflight}, {26'd0, e.infl});
    @(posedge clk); #1;
  endtask

  task automatic chk_state(string tag, logic exp);
    logic st;
    @(negedge clk);
    st = dut.r_state;
    chk1(tag, st, exp);
  endtask

  initial begin
    logic [31:0] b;
    total = 0; bad = 0;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    cyc("reset", 0, 0, 32'd0, 6'd0);
`ifdef ID_HAZARD_STALL_CNT_EN
    chkw("cnt_reset", {16'd0, stall_cnt}, 32'd0);
`endif

    // Load-to-use on x5
    id_valid = 1; id_rd = 5; id_writes_rd = 1;
    cyc("ltu_c0", 0, 1, 32'd0, 6'd0);
    idle(); id_valid = 1; id_rs1 = 5; id_uses_rs1 = 1;
    cyc("ltu_c1", 1, 0, 32'h20, 6'd1);
    cyc("ltu_c2", 1, 0, 32'h20, 6'd1);
    wb_valid = 1; wb_rd = 5;
    cyc("ltu_c3", 1, 0, 32'h20, 6'd1);
    wb_valid = 0;
    cyc("ltu_c4", 0, 1, 32'd0, 6'd0);

    // x0 is never tracked
    idle(); id_valid = 1; id_rd = 0; id_writes_rd = 1;
    cyc("x0_wr", 0, 1, 32'd0, 6'd0);
    idle(); id_valid = 1; id_rs1 = 0; id_uses_rs1 = 1;
    cyc("x0_use", 0, 1, 32'd0, 6'd0);
    idle(); wb_valid = 1; wb_rd = 0;
    cyc("x0_wb", 0, 0, 32'd0, 6'd0);
    idle();
    cyc("x0_after", 0, 0, 32'd0, 6'd0);

    // Same-register set and clear on x7
    id_valid = 1; id_rd = 7; id_writes_rd = 1;
    cyc("sr_set", 0, 1, 32'd0, 6'd0);
    wb_valid = 1; wb_rd = 7;
    cyc("sr_waw", 1, 0, 32'h80, 6'd1);
    cyc("sr_spur", 0, 1, 32'd0, 6'd0);
    idle();
    cyc("sr_after", 0, 0, 32'h80, 6'd1);
    wb_valid = 1; wb_rd = 7;
    cyc("sr_drain", 0, 0, 32'h80, 6'd1);
    idle();
    cyc("sr_empty", 0, 0, 32'd0, 6'd0);

    // Fill x1..x31 back to back
    b = 32'd0;
    for (int i = 1; i < 32; i++) begin
      idle(); id_valid = 1; id_rd = 5'(i); id_writes_rd = 1;
      cyc($sformatf("fill_%0d", i), 0, 1, b, 6'(i - 1));
      b[i] = 1'b1;
    end
    idle();
    cyc("fill_done", 0, 0, 32'hFFFFFFFE, 6'd31);

    // Flush while stalled
    id_valid = 1; id_rs1 = 3; id_uses_rs1 = 1;
    cyc("fl_stall", 1, 0, 32'hFFFFFFFE, 6'd31);
    flush = 1;
    chk_state("fl_state_stall", 1'b1);
    cyc("fl_flush", 0, 0, 32'hFFFFFFFE, 6'd31);
    idle();
    chk_state("fl_state_ready", 1'b0);
    cyc("fl_after", 0, 0, 32'hFFFFFFFE, 6'd31);

    // Drain x1..x31, including a write-back to an idle register
    for (int i = 1; i < 32; i++) begin
      idle(); wb_valid = 1; wb_rd = 5'(i);
      cyc($sformatf("drain_%0d", i), 0, 0, 32'hFFFFFFFF << i, 6'(32 - i));
    end
    idle(); wb_valid = 1; wb_rd = 5'd9;
    cyc("wb_idle_reg", 0, 0, 32'd0, 6'd0);
    idle();
    cyc("drain_done", 0, 0, 32'd0, 6'd0);

    // Reset during a stall with three writes pending
    for (int i = 2; i < 5; i++) begin
      idle(); id_valid = 1; id_rd = 5'(i); id_writes_rd = 1;
      cyc($sformatf("rm_set_%0d", i), 0, 1, (32'd1 << i) - 32'd4, 6'(i - 2));
    end
    idle(); id_valid = 1; id_rs1 = 2; id_uses_rs1 = 1;
    cyc("rm_stall", 1, 0, 32'h1C, 6'd3);
    rst = 1; id_writes_rd = 1; id_rd = 6; wb_valid = 1; wb_rd = 3;
    cyc("rm_rst", 0, 1, 32'h1C, 6'd3);
    rst = 0; idle();
    chk_state("rm_state", 1'b0);
    cyc("rm_after", 0, 0, 32'd0, 6'd0);

`ifdef ID_HAZARD_STALL_CNT_EN
    chkw("cnt_after_rst", {16'd0, stall_cnt}, 32'd0);
    id_valid = 1; id_rd = 9; id_writes_rd = 1;
    cyc("cnt_set", 0, 1, 32'd0, 6'd0);
    idle(); id_valid = 1; id_rs1 = 9; id_uses_rs1 = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chkw("cnt_5", {16'd0, stall_cnt}, 32'd5);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chkw("cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
